// File: rtl/flash_readback_engine_pkg.sv
// -----------------------------------------------------------------------------
// flash_readback_engine_pkg
//   Shared definitions for the flash readback engine.
//   - FSM state encoding
//   - Default geometry: flash word address width, length field width, timeout
//   - Register-file offsets where the Rb* command/status bits are mapped
// -----------------------------------------------------------------------------
package flash_readback_engine_pkg;

    localparam int RB_ADDR_W      = 18;
    localparam int RB_LEN_W       = 6;
    localparam int RB_TIMEOUT_CYC = 4096;

    // Register-file byte offsets for the readback block.
    localparam logic [7:0] RB_REG_CTRL     = 8'h40;  // RbStart / RbAck
    localparam logic [7:0] RB_REG_STATUS   = 8'h44;  // RbBusy / RbDone / RbError
    localparam logic [7:0] RB_REG_ADDR     = 8'h48;  // RbAddr
    localparam logic [7:0] RB_REG_LEN      = 8'h4C;  // RbLen
    localparam logic [7:0] RB_REG_CHECKSUM = 8'h50;  // RbChecksum
    localparam logic [7:0] RB_REG_MEM_BASE = 8'h80;  // readback buffer window

    typedef enum logic [2:0] {
        RB_IDLE      = 3'd0,
        RB_REQ       = 3'd1,
        RB_WAIT_DATA = 3'd2,
        RB_DONE      = 3'd3,
        RB_ERR       = 3'd4
    } rb_state_e;

endpackage

// File: rtl/flash_readback_engine_rb_buffer_ram.sv
// -----------------------------------------------------------------------------
// rb_buffer_ram
//   Simple dual-port readback buffer: 2**DEPTH_W words of 32 bits written by
//   the fetch FSM, read back as 16-bit halfwords with one cycle of latency.
// Ports
//   FpgaClk  in   system clock
//   RST      in   asynchronous active-high reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   word address for writes
//   wr_data  in   32-bit write data
//   rd_addr  in   halfword address (bit 0 selects the upper half)
//   rd_data  out  registered halfword
// -----------------------------------------------------------------------------
module rb_buffer_ram #(
    parameter int DEPTH_W = 6
) (
    input  logic               FpgaClk,
    input  logic               RST,
    input  logic               wr_en,
    input  logic [DEPTH_W-1:0] wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [DEPTH_W:0]   rd_addr,
    output logic [15:0]        rd_data
);

    logic [31:0] mem [0:(1 << DEPTH_W) - 1];
    logic [31:0] rd_word;
    logic [15:0] rd_data_d;
    logic [15:0] rd_data_q;

    // NOTE: the storage array has no reset so it can map onto block RAM;
    // only the output register is cleared.
    always_ff @(posedge FpgaClk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A same-cycle write to the word being read is not visible until the
    // following cycle, so the reader sees the old contents.
    always_comb begin
        rd_word   = mem[rd_addr[DEPTH_W:1]];
        rd_data_d = rd_addr[0] ? rd_word[31:16] : rd_word[15:0];
    end

    always_ff @(posedge FpgaClk or posedge RST) begin
        if (RST) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/flash_readback_engine.sv
// -----------------------------------------------------------------------------
// flash_readback_engine
//   Fetches 1..2**LEN_W consecutive 32-bit words from the on-chip flash
//   Avalon-MM data port into a readback buffer, one outstanding read at a time,
//   and accumulates a 16-bit sum of every halfword fetched.
// Ports
//   FpgaClk, RST             clock, asynchronous active-high reset
//   RbStart/RbAddr/RbLen     start pulse, first word address, word count (0 = max)
//   RbAck                    clears the sticky RbDone/RbError flags
//   RbBusy/RbDone/RbError    status
//   RbChecksum               running halfword sum of the current operation
//   RbMemRdAddress/Data      buffer halfword read port (1-cycle latency)
//   FlashAddr/Read/Wait/RdData/RdValid   Avalon-MM read master
// -----------------------------------------------------------------------------
module flash_readback_engine
    import flash_readback_engine_pkg::*;
#(
    parameter int ADDR_W      = RB_ADDR_W,
    parameter int LEN_W       = RB_LEN_W,
    parameter int TIMEOUT_CYC = RB_TIMEOUT_CYC
) (
    input  logic              FpgaClk,
    input  logic              RST,
    input  logic              RbStart,
    input  logic [ADDR_W-1:0] RbAddr,
    input  logic [LEN_W-1:0]  RbLen,
    input  logic              RbAck,
    output logic              RbBusy,
    output logic              RbDone,
    output logic              RbError,
    output logic [15:0]       RbChecksum,
    input  logic [LEN_W:0]    RbMemRdAddress,
    output logic [15:0]       RbMemRdData,
    output logic [ADDR_W-1:0] FlashAddr,
    output logic              FlashRead,
    input  logic              FlashWait,
    input  logic [31:0]       FlashRdData,
    input  logic              FlashRdValid
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    rb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LEN_W:0]    len_q,   len_d;    // word count, 1..2**LEN_W
    logic [LEN_W-1:0]  idx_q,   idx_d;
    logic [TMO_W-1:0]  tmo_q,   tmo_d;
    logic [15:0]       chk_q,   chk_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              error_q, error_d;

    logic [LEN_W:0]    start_len;
    logic [ADDR_W:0]   start_end;
    logic              range_err;
    logic              last_word;
    logic              buf_wr_en;

    // A zero length field encodes the full buffer; the end address is checked
    // with one extra bit so an operation reaching exactly the top is legal.
    always_comb begin
        start_len = (RbLen == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, RbLen};
        start_end = {1'b0, RbAddr} + {{(ADDR_W - LEN_W){1'b0}}, start_len};
        range_err = start_end > {1'b1, {ADDR_W{1'b0}}};
        last_word = ({1'b0, idx_q} == (len_q - 1'b1));
    end

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        chk_d     = chk_q;
        busy_d    = busy_q;
        // Ack clears the sticky flags; any set below overrides it.
        done_d    = done_q  & ~RbAck;
        error_d   = error_q & ~RbAck;
        buf_wr_en = 1'b0;

        case (state_q)
            // DONE/ERR last one cycle and accept a new start like IDLE.
            RB_IDLE, RB_DONE, RB_ERR: begin
                state_d = RB_IDLE;
                if (RbStart) begin
                    addr_d  = RbAddr;
                    len_d   = start_len;
                    idx_d   = '0;
                    chk_d   = '0;
                    tmo_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    if (range_err) begin
                        state_d = RB_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = RB_REQ;
                        busy_d  = 1'b1;
                    end
                end
            end
            RB_REQ: begin
                if (!FlashWait) begin
                    state_d = RB_WAIT_DATA;
                    tmo_d   = '0;
                end
            end
            RB_WAIT_DATA: begin
                if (FlashRdValid) begin
                    buf_wr_en = 1'b1;
                    chk_d     = chk_q + FlashRdData[15:0] + FlashRdData[31:16];
                    idx_d     = idx_q + 1'b1;
                    addr_d    = addr_q + 1'b1;
                    if (last_word) begin
                        state_d = RB_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RB_REQ;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = RB_ERR;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = RB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge FpgaClk or posedge RST) begin
        if (RST) begin
            state_q <= RB_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            chk_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            chk_q   <= chk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Decoded straight from the state register so reset drops it at once.
    assign FlashRead  = (state_q == RB_REQ);
    assign FlashAddr  = addr_q;
    assign RbBusy     = busy_q;
    assign RbDone     = done_q;
    assign RbError    = error_q;
    assign RbChecksum = chk_q;

    rb_buffer_ram #(
        .DEPTH_W (LEN_W)
    ) u_buffer (
        .FpgaClk (FpgaClk),
        .RST     (RST),
        .wr_en   (buf_wr_en),
        .wr_addr (idx_q),
        .wr_data (FlashRdData),
        .rd_addr (RbMemRdAddress),
        .rd_data (RbMemRdData)
    );

endmodule

// File: tb/tb_flash_readback_engine.sv
// -----------------------------------------------------------------------------
// tb_flash_readback_engine
//   Directed and randomized checks of flash_readback_engine against an Avalon
//   flash responder and a word-level model of the buffer and checksum.
// -----------------------------------------------------------------------------
module tb_flash_readback_engine;

    logic        FpgaClk = 1'b0;
    logic        RST;
    logic        RbStart;
    logic [17:0] RbAddr;
    logic [5:0]  RbLen;
    logic        RbAck;
    logic        RbBusy;
    logic        RbDone;
    logic        RbError;
    logic [15:0] RbChecksum;
    logic [6:0]  RbMemRdAddress;
    logic [15:0] RbMemRdData;
    logic [17:0] FlashAddr;
    logic        FlashRead;
    logic        FlashWait;
    logic [31:0] FlashRdData;
    logic        FlashRdValid;

    flash_readback_engine dut (
        .FpgaClk        (FpgaClk),
        .RST            (RST),
        .RbStart        (RbStart),
        .RbAddr         (RbAddr),
        .RbLen          (RbLen),
        .RbAck          (RbAck),
        .RbBusy         (RbBusy),
        .RbDone         (RbDone),
        .RbError        (RbError),
        .RbChecksum     (RbChecksum),
        .RbMemRdAddress (RbMemRdAddress),
        .RbMemRdData    (RbMemRdData),
        .FlashAddr      (FlashAddr),
        .FlashRead      (FlashRead),
        .FlashWait      (FlashWait),
        .FlashRdData    (FlashRdData),
        .FlashRdValid   (FlashRdValid)
    );

    always #5 FpgaClk = ~FpgaClk;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int fail_cnt  = 0;

    // Responder controls and observations.
    bit          in_req, pend, no_valid;
    int          wait_left, pend_lat, lat_min, lat_max, wait_max;
    int          wait_on_req, wait_len, req_seen;
    logic [17:0] req_addr;
    logic [31:0] pend_data;
    logic [17:0] addr_log [$];
    logic [31:0] resp_q [$];

    // Model of buffer contents; entries never written are unknown.
    logic [31:0] exp_buf   [64];
    bit          exp_valid [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_sum(input logic [31:0] words [$]);
        int s = 0;
        foreach (words[i]) s += int'(words[i][15:0]) + int'(words[i][31:16]);
        return s[15:0];
    endfunction

    // Avalon slave: random waitrequest, single response after random latency.
    initial begin
        FlashWait = 1'b0; FlashRdValid = 1'b0; FlashRdData = '0;
        forever begin
            @(negedge FpgaClk);
            FlashRdValid = 1'b0;
            if (pend) begin
                if (pend_lat == 0) begin
                    FlashRdValid = 1'b1;
                    FlashRdData  = pend_data;
                    pend         = 1'b0;
                end else begin
                    pend_lat--;
                end
            end
            if (FlashRead) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    req_seen++;
                    req_addr = FlashAddr;
                    wait_left = (addr_log.size() + 1 == wait_on_req) ? wait_len
                                                                       : int'($urandom_range(wait_max, 0));
                end else begin
                    check("addr_stable", FlashAddr, req_addr);
                end
                if (wait_left > 0) begin
                    FlashWait = 1'b1;
                    wait_left--;
                end else begin
                    FlashWait = 1'b0;
                    in_req    = 1'b0;
                    addr_log.push_back(FlashAddr);
                    if (!no_valid) begin
                        pend      = 1'b1;
                        pend_lat  = int'($urandom_range(lat_max, lat_min));
                        pend_data = (resp_q.size() > 0) ? resp_q.pop_front() : 32'hDEAD_BEEF;
                    end
                end
            end else begin
                FlashWait = 1'b0;
                if (in_req) begin
                    check("read_held", 32'd0, 32'd1);
                    in_req = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_random(input int n);
        resp_q.delete();
        repeat (n) resp_q.push_back($urandom);
    endtask

    task automatic rd_half(input logic [6:0] a, output logic [15:0] d);
        @(negedge FpgaClk);
        RbMemRdAddress = a;
        @(negedge FpgaClk);
        d = RbMemRdData;
    endtask

    task automatic check_buffer();
        logic [31:0] w;
        logic [6:0]  a = '0;
        @(negedge FpgaClk);
        RbMemRdAddress = a;
        for (int i = 0; i < 128; i++) begin
            @(negedge FpgaClk);
            if (exp_valid[i / 2]) begin
                w = exp_buf[i / 2];
                check($sformatf("buf[%0d]", i), RbMemRdData, (i % 2) ? w[31:16] : w[15:0]);
            end
            a = a + 7'd1;
            RbMemRdAddress = a;
        end
    endtask

    task automatic ack();
        @(negedge FpgaClk);
        RbAck = 1'b1;
        @(negedge FpgaClk);
        RbAck = 1'b0;
        check("ack_done", RbDone, 0);
        check("ack_err", RbError, 0);
    endtask

    // Runs one operation using the words queued in resp_q and checks the outcome.
    task automatic run_op(input logic [17:0] addr, input int len, input bit exp_err, input bit inject);
        int          n, cyc, reqs0;
        logic [31:0] words [$];
        logic [17:0] ea;
        n     = (len == 0) ? 64 : len;
        words = resp_q;
        addr_log.delete();
        reqs0 = req_seen;
        @(negedge FpgaClk);
        RbAddr = addr; RbLen = 6'(len); RbStart = 1'b1;
        @(negedge FpgaClk);
        RbStart = 1'b0;
        check("start_busy", RbBusy, exp_err ? 0 : 1);
        check("start_err", RbError, exp_err);
        check("start_done_clr", RbDone, 0);
        cyc = 0;
        while (!(RbDone || RbError) && cyc < 6000) begin
            @(negedge FpgaClk);
            cyc++;
            if (inject && cyc == 2) begin
                RbAddr = 18'h3FFFF; RbLen = 6'd7; RbStart = 1'b1;
            end else begin
                RbStart = 1'b0;
            end
        end
        RbStart = 1'b0;
        check("op_finished", RbDone | RbError, 1);
        check("end_done", RbDone, !exp_err);
        check("end_err", RbError, exp_err);
        check("end_busy", RbBusy, 0);
        if (exp_err) begin
            check("no_reads", req_seen - reqs0, 0);
            check("err_checksum", RbChecksum, 0);
        end else begin
            check("checksum", RbChecksum, model_sum(words));
            check("read_count", addr_log.size(), n);
            for (int i = 0; i < n && i < addr_log.size(); i++) begin
                ea = addr + 18'(i);
                check($sformatf("addr[%0d]", i), addr_log[i], ea);
            end
            for (int i = 0; i < n; i++) begin
                exp_buf[i]   = words[i];
                exp_valid[i] = 1'b1;
            end
            check_buffer();
        end
    endtask

    initial begin
        logic [15:0] d;
        logic [31:0] w;
        int          cyc;
        RST = 1'b1; RbStart = 1'b0; RbAck = 1'b0; RbAddr = '0; RbLen = '0; RbMemRdAddress = '0;
        in_req = 1'b0; pend = 1'b0; no_valid = 1'b0; req_seen = 0;
        wait_max = 0; lat_min = 0; lat_max = 0; wait_on_req = 0; wait_len = 0;
        foreach (exp_valid[i]) exp_valid[i] = 1'b0;

        // Reset state.
        repeat (3) @(negedge FpgaClk);
        check("rst_busy", RbBusy, 0);
        check("rst_done", RbDone, 0);
        check("rst_err", RbError, 0);
        check("rst_checksum", RbChecksum, 0);
        check("rst_memdata", RbMemRdData, 0);
        check("rst_faddr", FlashAddr, 0);
        check("rst_fread", FlashRead, 0);
        RST = 1'b0;

        // Known pattern, zero wait, zero latency.
        resp_q = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        run_op(18'h00100, 4, 0, 0);
        check("pattern_checksum", RbChecksum, 16'h6664);
        rd_half(7'd0, d);
        check("pattern_buf0", d, 16'h2222);
        rd_half(7'd1, d);
        check("pattern_buf1", d, 16'h1111);
        ack();

        // Full-length operation from address 0.
        lat_max = 2;
        fill_random(64);
        run_op(18'h00000, 0, 0, 0);
        rd_half(7'd127, d);
        w = exp_buf[63];
        check("last_high_half", d, w[31:16]);
        ack();

        // Waitrequest held 10 cycles on the 2nd read; a start while busy is ignored.
        wait_on_req = 2; wait_len = 10;
        fill_random(5);
        run_op(18'h00200, 5, 0, 1);
        wait_on_req = 0;
        ack();

        // No readdatavalid: timeout error.
        no_valid = 1'b1;
        resp_q.delete();
        addr_log.delete();
        @(negedge FpgaClk);
        RbAddr = 18'h00300; RbLen = 6'd2; RbStart = 1'b1;
        @(negedge FpgaClk);
        RbStart = 1'b0;
        cyc = 0;
        while (!RbError && cyc < 6000) begin
            @(negedge FpgaClk);
            cyc++;
        end
        check("tmo_error", RbError, 1);
        check("tmo_busy", RbBusy, 0);
        check("tmo_done", RbDone, 0);
        check("tmo_window", (cyc >= 4094 && cyc <= 4098), 1);
        check("tmo_reads", addr_log.size(), 1);
        no_valid = 1'b0;
        ack();

        // Range boundary: one word past the top fails, exactly to the top passes.
        resp_q.delete();
        run_op(18'h3FFFE, 3, 1, 0);
        ack();
        fill_random(2);
        run_op(18'h3FFFE, 2, 0, 0);

        // Random operations; unacknowledged ones are cleared by the next start.
        wait_max = 3; lat_max = 4;
        for (int k = 0; k < 6; k++) begin
            int          len;
            logic [17:0] a;
            len = int'($urandom_range(63, 0));
            a   = 18'($urandom_range(32'h3FFBF, 0));
            fill_random((len == 0) ? 64 : len);
            run_op(a, len, 0, 0);
            if (k % 2 == 1) ack();
        end
        wait_max = 0; lat_max = 0;

        // Reset while a read request is being held: FlashRead drops at once.
        wait_on_req = 1; wait_len = 50;
        fill_random(4);
        addr_log.delete();
        @(negedge FpgaClk);
        RbAddr = 18'h00400; RbLen = 6'd4; RbStart = 1'b1;
        @(negedge FpgaClk);
        RbStart = 1'b0;
        cyc = 0;
        while (!FlashRead && cyc < 20) begin
            @(negedge FpgaClk);
            cyc++;
        end
        check("rst_req_seen", FlashRead, 1);
        #2 RST = 1'b1;
        in_req = 1'b0; wait_left = 0; pend = 1'b0; wait_on_req = 0;
        resp_q.delete();
        #1;
        check("async_fread", FlashRead, 0);
        check("async_busy", RbBusy, 0);
        check("async_faddr", FlashAddr, 0);
        check("async_memdata", RbMemRdData, 0);
        @(negedge FpgaClk);
        #2 RST = 1'b0;

        // Reset while waiting for data; the late readdatavalid must be ignored.
        lat_min = 8; lat_max = 8;
        fill_random(2);
        addr_log.delete();
        @(negedge FpgaClk);
        RbAddr = 18'h00500; RbLen = 6'd2; RbStart = 1'b1;
        @(negedge FpgaClk);
        RbStart = 1'b0;
        cyc = 0;
        while (addr_log.size() == 0 && cyc < 20) begin
            @(negedge FpgaClk);
            cyc++;
        end
        check("late_req_accepted", addr_log.size(), 1);
        @(negedge FpgaClk);
        #2 RST = 1'b1;
        @(negedge FpgaClk);
        #2 RST = 1'b0;
        repeat (12) @(negedge FpgaClk);
        check("late_valid_sent", pend, 0);
        check("late_busy", RbBusy, 0);
        check("late_done", RbDone, 0);
        check("late_err", RbError, 0);
        check("late_checksum", RbChecksum, 0);
        check("late_fread", FlashRead, 0);
        check("late_faddr", FlashAddr, 0);
        check_buffer();
        lat_min = 0; lat_max = 2;
        fill_random(3);
        run_op(18'h00600, 3, 0, 0);
        ack();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
